// File: rtl/muldiv_seq_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
// Operation codes, sequencer states and the ALU opcode defines.
`ifndef ADD
`define ADD 6'b100000
`endif
`ifndef SUB
`define SUB 6'b100010
`endif

package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic sel_hi(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer.
// Borrows the shared execute-stage ALU for every add/subtract step.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [5:0]      alu_control,
  output logic [XLEN-1:0] alu_op_a,
  output logic [XLEN-1:0] alu_op_b,
  input  logic [XLEN-1:0] alu_result
);

  state_e          state_q;
  op_e             op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] acc_d;
  logic [XLEN-1:0] sh_q;
  logic [XLEN-1:0] sh_d;
  logic [XLEN-1:0] opb_q;
  logic [XLEN-1:0] res_q;
  logic            busy_q;
  logic            done_q;

  logic [XLEN-1:0] shifted;
  logic            top;
  logic            sub_ok;
  logic            carry;
  logic            run_mul;
  logic            run_div;
  logic [XLEN-1:0] res_sel;
  logic            last_iter;
  logic            div_zero;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

  // acc holds hi (mul) or rem (div); sh holds lo or quo
  assign shifted = {acc_q[XLEN-2:0], sh_q[XLEN-1]};
  assign top     = acc_q[XLEN-1];
  assign sub_ok  = top | (shifted >= opb_q);
  assign carry   = alu_result < acc_q;

  assign run_mul = (state_q == RUN) & ~is_div(op_q);
  assign run_div = (state_q == RUN) & is_div(op_q);

  assign last_iter = cnt_q == CNT_W'(XLEN - 1);
  assign div_zero  = is_div(op) & (src_b == '0);

  always_comb begin
    alu_control = `ADD;
    alu_op_a    = '0;
    alu_op_b    = '0;
    unique case (1'b1)
      run_mul: begin
        alu_control = `ADD;
        alu_op_a    = acc_q;
        alu_op_b    = opb_q;
      end
      run_div: begin
        alu_control = `SUB;
        alu_op_a    = shifted;
        alu_op_b    = opb_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    sh_d  = sh_q;
    if (is_div(op_q)) begin
      if (sub_ok) begin
        acc_d = alu_result;
        sh_d  = {sh_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = shifted;
        sh_d  = {sh_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (sh_q[0]) begin
        acc_d = {carry, alu_result[XLEN-1:1]};
        sh_d  = {alu_result[0], sh_q[XLEN-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[XLEN-1:1]};
        sh_d  = {acc_q[0], sh_q[XLEN-1:1]};
      end
    end
  end

  assign res_sel = sel_hi(op_q) ? acc_d : sh_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !kill) begin
            op_q   <= op_e'(op);
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= is_div(op) ? src_a : src_b;
            opb_q  <= is_div(op) ? src_b : src_a;
            busy_q <= 1'b1;
            if (div_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              res_q   <= sel_hi(op) ? src_a : '1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              res_q   <= res_sel;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural shared ALU.
// Directed vectors; a negedge monitor checks every done pulse.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        kill    = 1'b0;
  logic [1:0]  op      = 2'b00;
  logic [31:0] src_a   = '0;
  logic [31:0] src_b   = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [5:0]  alu_control;
  logic [31:0] alu_op_a;
  logic [31:0] alu_op_b;
  logic [31:0] alu_result;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          c0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb[$];

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .kill       (kill),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .alu_control(alu_control),
    .alu_op_a   (alu_op_a),
    .alu_op_b   (alu_op_b),
    .alu_result (alu_result)
  );

  assign alu_result = (alu_control == `SUB) ? alu_op_a - alu_op_b
                                            : alu_op_a + alu_op_b;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done cycle=%0d result=%h", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_result"}, result, e.res);
        chk({e.nm, "_done_cycle"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input bit push, input string nm);
    @(posedge clock);
    #1;
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (push) sb.push_back(exp_t'{res: exp, at: cyc + lat, nm: nm});
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input string nm, input bit noise);
    int n;
    n = 0;
    issue(o, a, b, exp, lat, 1'b1, nm);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy) break;
      n++;
      if (o[1] && b == 32'd0) begin
        chk({nm, "_alu_a"}, alu_op_a, 32'd0);
        chk({nm, "_alu_b"}, alu_op_b, 32'd0);
      end
      if (noise) begin
        start = (n >= 2 && n <= 20);
        op    = OP_MUL;
        src_a = '0;
        src_b = '0;
      end
    end
    start = 1'b0;
    chk({nm, "_busy_len"}, 32'(n), 32'(lat));
    chk({nm, "_held"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_ctl", 32'(alu_control), 32'(`ADD));
    chk("rst_alu_a", alu_op_a, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op(OP_MUL,   32'd7, 32'd6, 32'h0000002A, 33, "mul_7x6", 1'b0);
    repeat (3) @(negedge clock);
    chk("mul_7x6_hold", result, 32'h0000002A);
    run_op(OP_MULHU, '1, '1, 32'hFFFFFFFE, 33, "mulhu_ff", 1'b0);
    run_op(OP_MUL,   '1, '1, 32'h00000001, 33, "mul_ff", 1'b0);
    run_op(OP_DIVU,  32'd100, 32'd7, 32'h0000000E, 33, "divu_100_7", 1'b1);
    run_op(OP_REMU,  32'd100, 32'd7, 32'h00000002, 33, "remu_100_7", 1'b0);
    run_op(OP_DIVU,  32'h80000000, 32'd1, 32'h80000000, 33, "divu_top", 1'b0);
    run_op(OP_DIVU,  32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by0", 1'b0);
    run_op(OP_REMU,  32'd5, 32'd0, 32'h00000005, 1, "remu_by0", 1'b0);

    issue(OP_MUL, 32'd9, 32'd9, 32'd81, 33, 1'b1, "b2b_a");
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_a_seen", 32'(seen), 32'd1);
    issue(OP_MULHU, 32'h00010000, 32'h00030000, 32'd3, 33, 1'b1, "b2b_b");
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk("b2b_b_held", result, 32'd3);
    last_res = 32'd3;

    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0, "kill");
    c0 = cyc - 1;
    while (cyc < c0 + 10) begin
      @(posedge clock);
      #1;
    end
    kill = 1'b1;
    @(posedge clock);
    #1;
    kill = 1'b0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_result", result, last_res);
    run_op(OP_REMU, 32'd100, 32'd7, 32'h00000002, 33, "after_kill", 1'b0);

    @(posedge clock);
    #1;
    start = 1'b1;
    kill  = 1'b1;
    op    = OP_DIVU;
    src_a = 32'd50;
    src_b = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    kill  = 1'b0;
    @(negedge clock);
    chk("kill_start_busy", 32'(busy), 32'd0);

    issue(OP_MUL, 32'h1234, 32'h5678, 32'd0, 0, 1'b0, "rst");
    c0 = cyc - 1;
    while (cyc < c0 + 15) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_op(OP_MUL, 32'd3, 32'd5, 32'h0000000F, 33, "mul_3x5", 1'b0);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
